// File: rtl/bus_initiator_pkg.sv
// Shared femto bus constants and helpers for bus_initiator.
// Access-size codes, status codes and alignment/read-data rules.
package bus_initiator_pkg;

    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    localparam logic [1:0] BUS_ST_OK       = 2'd0;
    localparam logic [1:0] BUS_ST_FAULT    = 2'd1;
    localparam logic [1:0] BUS_ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] BUS_ST_MISALIGN = 2'd3;

    function automatic logic acc_misaligned(
        input logic [BUS_ACC_WIDTH-1:0] acc,
        input logic [1:0]               addr_lo
    );
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            acc == BUS_ACC_2B: bad = addr_lo[0];
            acc == BUS_ACC_4B: bad = |addr_lo;
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [BUS_WIDTH-1:0] acc_rdata(
        input logic [BUS_ACC_WIDTH-1:0] acc,
        input logic [BUS_WIDTH-1:0]     data
    );
        logic [BUS_WIDTH-1:0] res;
        res = data;
        unique case (1'b1)
            acc == BUS_ACC_1B: res = {24'd0, data[7:0]};
            acc == BUS_ACC_2B: res = {16'd0, data[15:0]};
            default:           res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bus_init_timer.sv
// WAIT-state timeout counter for bus_initiator.
// Only instantiated when BUS_INITIATOR_TIMEOUT_EN is defined.
module bus_init_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding femto bus initiator driven by a valid/ready command stream.
// Optional WAIT timeout built when BUS_INITIATOR_TIMEOUT_EN is defined.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic                     cmd_w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] cmd_acc,
    input  logic [BUS_WIDTH-1:0]     cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_status,
    output logic [BUS_WIDTH-1:0]     rsp_rdata,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic                     w_rb,
    output logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     wdata,
    output logic                     req,
    input  logic                     resp,
    input  logic                     fault,
    input  logic [BUS_WIDTH-1:0]     rdata
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("bus_initiator: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic                     req_q, req_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [1:0]               rsp_status_q, rsp_status_d;
    logic [BUS_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     w_rb_q, w_rb_d;
    logic [BUS_ACC_WIDTH-1:0] acc_q, acc_d;
    logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
    logic [BUS_WIDTH-1:0]     ok_rdata;

`ifdef BUS_INITIATOR_TIMEOUT_EN
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    bus_init_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );
`endif

    // Writes never return data; reads keep only the accessed bytes.
    assign ok_rdata = w_rb_q ? '0 : acc_rdata(acc_q, rdata);

    always_comb begin
        state_d      = state_q;
        rsp_status_d = rsp_status_q;
        rsp_rdata_d  = rsp_rdata_q;
        addr_d       = addr_q;
        w_rb_d       = w_rb_q;
        acc_d        = acc_q;
        wdata_d      = wdata_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    w_rb_d  = cmd_w_rb;
                    acc_d   = cmd_acc;
                    wdata_d = cmd_wdata;
                    if (acc_misaligned(cmd_acc, cmd_addr[1:0])) begin
                        state_d      = S_DONE;
                        rsp_status_d = BUS_ST_MISALIGN;
                        rsp_rdata_d  = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (fault) begin
                    state_d      = S_DONE;
                    rsp_status_d = BUS_ST_FAULT;
                    rsp_rdata_d  = '0;
                end else if (resp) begin
                    state_d      = S_DONE;
                    rsp_status_d = BUS_ST_OK;
                    rsp_rdata_d  = ok_rdata;
                end else begin
                    state_d = S_WAIT;
`ifdef BUS_INITIATOR_TIMEOUT_EN
                    tmr_clr = 1'b1;
`endif
                end
            end
            S_WAIT: begin
                if (resp) begin
                    state_d      = S_DONE;
                    rsp_status_d = BUS_ST_OK;
                    rsp_rdata_d  = ok_rdata;
                end
`ifdef BUS_INITIATOR_TIMEOUT_EN
                else if (tmr_expired) begin
                    state_d      = S_DONE;
                    rsp_status_d = BUS_ST_TIMEOUT;
                    rsp_rdata_d  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d       = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'd0;
            rsp_rdata_q  <= '0;
            addr_q       <= '0;
            w_rb_q       <= 1'b0;
            acc_q        <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_rdata_q  <= rsp_rdata_d;
            addr_q       <= addr_d;
            w_rb_q       <= w_rb_d;
            acc_q        <= acc_d;
            wdata_q      <= wdata_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign req        = req_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign addr       = addr_q;
    assign w_rb       = w_rb_q;
    assign acc        = acc_q;
    assign wdata      = wdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed cases then random traffic.
// Expected results come from a size/latency model of the bus rules.
module tb_bus_initiator;
    import bus_initiator_pkg::*;

    localparam int AW  = 8;
    localparam int TMO = 4;
`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_w_rb;
    logic [1:0]    cmd_acc;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] addr;
    logic          w_rb;
    logic [1:0]    acc;
    logic [31:0]   wdata;
    logic          req;
    logic          resp;
    logic          fault;
    logic [31:0]   rdata;

    int tests = 0;
    int fails = 0;

    bus_initiator #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_w_rb   (cmd_w_rb),
        .cmd_acc    (cmd_acc),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_rdata  (rsp_rdata),
        .addr       (addr),
        .w_rb       (w_rb),
        .acc        (acc),
        .wdata      (wdata),
        .req        (req),
        .resp       (resp),
        .fault      (fault),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k = cycles from the req cycle to resp (0 = same cycle).
    function automatic void model(
        input  logic [AW-1:0] a,
        input  logic [1:0]    ac,
        input  logic          w,
        input  int            k,
        input  bit            flt,
        input  logic [31:0]   rd,
        output logic [1:0]    st,
        output logic [31:0]   d,
        output int            lat
    );
        int sz;
        longint unsigned m;
        sz  = 1 << ac;
        m   = 64'd1 << (8 * sz);
        d   = 32'd0;
        if ((int'(a) % sz) != 0) begin
            st  = 2'd3;
            lat = 1;
        end else if (flt) begin
            st  = 2'd1;
            lat = 2;
        end else if (TMO_EN && k > TMO) begin
            st  = 2'd2;
            lat = 2 + TMO;
        end else begin
            st  = 2'd0;
            lat = 2 + k;
            if (!w) d = 32'(longint'(rd) % m);
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input logic [AW-1:0] a,
                       input logic w, input logic [1:0] ac,
                       input logic [31:0] wd, input int k, input bit flt,
                       input logic [31:0] rd, input int rdy_dly);
        logic [1:0]  est;
        logic [31:0] edat;
        int          elat;
        int          got;
        int          i;
        model(a, ac, w, k, flt, rd, est, edat, elat);
        check({tag, ".cmd_ready_idle"}, cmd_ready, 1'b1);
        cmd_addr  = a;
        cmd_w_rb  = w;
        cmd_acc   = ac;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        rdata     = rd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = -1;
        i   = 1;
        while (got < 0 && i <= 40) begin
            if (rsp_valid) begin
                got = i;
            end else begin
                check({tag, ".req"}, req, (i == 1));
                check({tag, ".cmd_ready_busy"}, cmd_ready, 1'b0);
                if (i == 1) begin
                    check({tag, ".bus_addr"}, addr, a);
                    check({tag, ".bus_w_rb"}, w_rb, w);
                    check({tag, ".bus_acc"}, acc, ac);
                    check({tag, ".bus_wdata"}, wdata, wd);
                end
                resp  = !flt && (i == 1 + k);
                fault = flt ? (i == 1) : (i >= 2 && $urandom_range(0, 1) == 1);
                @(posedge clk); #1;
                resp  = 1'b0;
                fault = 1'b0;
                i++;
            end
        end
        check({tag, ".latency"}, got, elat);
        if (got < 0) begin
            do_reset();
            return;
        end
        check({tag, ".status"}, rsp_status, est);
        check({tag, ".rdata"}, rsp_rdata, edat);
        check({tag, ".cmd_ready_done"}, cmd_ready, 1'b0);
        check({tag, ".req_done"}, req, 1'b0);
        for (int j = 0; j < rdy_dly; j++) begin
            resp  = (j == 0);
            rdata = $urandom;
            @(posedge clk); #1;
            resp = 1'b0;
            check({tag, ".hold_valid"}, rsp_valid, 1'b1);
            check({tag, ".hold_status"}, rsp_status, est);
            check({tag, ".hold_rdata"}, rsp_rdata, edat);
            check({tag, ".hold_cmd_ready"}, cmd_ready, 1'b0);
        end
        resp      = (rdy_dly == 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        resp      = 1'b0;
        check({tag, ".post_valid"}, rsp_valid, 1'b0);
        check({tag, ".post_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, ".post_addr_hold"}, addr, a);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [1:0]    rac;
        int            rk;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_w_rb  = 1'b0;
        cmd_acc   = 2'd0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        resp      = 1'b0;
        fault     = 1'b0;
        rdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.cmd_ready", cmd_ready, 1'b1);
        check("rst.req", req, 1'b0);
        check("rst.rsp_valid", rsp_valid, 1'b0);
        check("rst.status", rsp_status, 2'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check("rst.addr", addr, 8'd0);
        check("rst.w_rb", w_rb, 1'b0);
        check("rst.acc", acc, 2'd0);
        check("rst.wdata", wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("wr1b_reg", 8'h00, 1'b1, 2'd0, 32'h0, 1, 1'b0, 32'h1234_5678, 0);
        run("wr4b_fault", 8'h00, 1'b1, 2'd2, 32'hDEAD_BEEF, 0, 1'b1,
            32'hFFFF_FFFF, 1);
        run("rd2b_noresp", 8'h04, 1'b0, 2'd1, 32'h0, TMO_EN ? 99 : 8, 1'b0,
            32'h0000_BEEF, 2);
        run("rd4b_misalign", 8'h02, 1'b0, 2'd2, 32'h0, 0, 1'b0,
            32'h1111_1111, 1);
        run("rd1b_hold", 8'h11, 1'b0, 2'd0, 32'h0, 0, 1'b0,
            32'hA5A5_A5A5, 3);
        run("rd4b_ok", 8'h08, 1'b0, 2'd2, 32'h0, TMO, 1'b0,
            32'hCAFE_F00D, 0);

        // Abandon a transaction sitting in WAIT.
        cmd_addr  = 8'h20;
        cmd_w_rb  = 1'b0;
        cmd_acc   = 2'd0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rstwait.in_wait", cmd_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("rstwait.req", req, 1'b0);
        check("rstwait.rsp_valid", rsp_valid, 1'b0);
        check("rstwait.cmd_ready", cmd_ready, 1'b1);
        check("rstwait.addr", addr, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run("after_rst", 8'h06, 1'b0, 2'd1, 32'h0, 2, 1'b0, 32'h7788_99AA, 1);

        for (int n = 0; n < 24; n++) begin
            ra  = AW'($urandom);
            rac = 2'($urandom_range(0, 2));
            rk  = TMO_EN ? int'($urandom_range(0, TMO + 2))
                         : int'($urandom_range(0, 6));
            run("rand", ra, 1'($urandom), rac, $urandom, rk,
                $urandom_range(0, 4) == 0, $urandom,
                int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin
                resp = 1'($urandom);
                @(posedge clk); #1;
            end
            resp = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
